// File: rtl/outgoing_port_handler_pkg.sv
// Shared router definitions for the outgoing port handler.
// Contents:
//   - link field widths (router address, memory offset, destination, payload)
//   - packed link-word struct and its field offsets
//   - port FSM state enum
//   - a helper that resolves the operation bits of a captured word
package outgoing_port_handler_pkg;

  localparam int ROUTER_ADDR_W = 6;
  localparam int MEM_ADDR_W    = 8;
  localparam int DEST_W        = ROUTER_ADDR_W + MEM_ADDR_W;
  localparam int DATA_W        = 8;

  // One word on the outgoing link, most significant field first.
  typedef struct packed {
    logic [DEST_W-1:0]        dest;
    logic [ROUTER_ADDR_W-1:0] requester;
    logic                     read;
    logic                     write;
    logic [DATA_W-1:0]        data;
  } link_word_t;

  localparam int LW_DATA_LSB      = 0;
  localparam int LW_WRITE_BIT     = LW_DATA_LSB + DATA_W;
  localparam int LW_READ_BIT      = LW_WRITE_BIT + 1;
  localparam int LW_REQUESTER_LSB = LW_READ_BIT + 1;
  localparam int LW_DEST_LSB      = LW_REQUESTER_LSB + ROUTER_ADDR_W;
  localparam int LINK_W           = LW_DEST_LSB + DEST_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // A word requesting both read and write is forwarded as a write; the read
  // bit is dropped. Returns {read, write}.
  function automatic logic [1:0] resolve_op(input logic rd, input logic wr);
    return {rd & ~wr, wr};
  endfunction

endpackage

// File: rtl/outgoing_port_handler_if.sv
// Outgoing link of a router port.
// Signals:
//   destinationAddressOut  destination router + memory offset
//   requesterAddressOut    router address of the original requester
//   readOut / writeOut     operation
//   dataOut                payload
//   validOut               word valid (held until accepted)
//   readyIn                downstream accepts the word this cycle
// Modports: master = transmitting port handler, slave = receiving handler.
interface outgoing_port_handler_if;
  import outgoing_port_handler_pkg::*;

  logic [DEST_W-1:0]        destinationAddressOut;
  logic [ROUTER_ADDR_W-1:0] requesterAddressOut;
  logic                     readOut;
  logic                     writeOut;
  logic [DATA_W-1:0]        dataOut;
  logic                     validOut;
  logic                     readyIn;

  modport master (
    output destinationAddressOut,
    output requesterAddressOut,
    output readOut,
    output writeOut,
    output dataOut,
    output validOut,
    input  readyIn
  );

  modport slave (
    input  destinationAddressOut,
    input  requesterAddressOut,
    input  readOut,
    input  writeOut,
    input  dataOut,
    input  validOut,
    output readyIn
  );
endinterface

// File: rtl/outgoing_port_handler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i    N-bit request vector
//   ptr_i    index with highest priority this cycle (0..N-1)
//   grant_o  one-hot grant of the first request at or after ptr_i (wrapping)
//   idx_o    binary index of the granted request
//   any_o    at least one request present
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [PTR_W:0] cand;
  logic           found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(N)) begin
        cand = cand - (PTR_W+1)'(N);
      end
      if (!found && req_i[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        idx_o = cand[PTR_W-1:0];
      end
    end
    if (found) begin
      grant_o[idx_o] = 1'b1;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/outgoing_port_handler.sv
// Transmit side of a router port.
// Collects words steered to this output by the incoming handlers, picks one by
// round-robin and holds it on the outgoing link until the downstream handler
// accepts it.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   reqValid             per-source request
//   reqDestAddr          packed destination addresses (DEST_W per source)
//   reqRequesterAddr     packed requester addresses (ROUTER_ADDR_W per source)
//   reqRead / reqWrite   per-source operation bits
//   reqData              packed payloads (DATA_W per source)
//   reqGrant             one-cycle pulse: that source's word was captured
//   protocolError        one-cycle pulse: captured word had read and write set
//   link                 outgoing link (master side)
module outgoing_port_handler
  import outgoing_port_handler_pkg::*;
#(
  parameter int NUM_SOURCES = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_SOURCES-1:0]               reqValid,
  input  logic [NUM_SOURCES*DEST_W-1:0]        reqDestAddr,
  input  logic [NUM_SOURCES*ROUTER_ADDR_W-1:0] reqRequesterAddr,
  input  logic [NUM_SOURCES-1:0]               reqRead,
  input  logic [NUM_SOURCES-1:0]               reqWrite,
  input  logic [NUM_SOURCES*DATA_W-1:0]        reqData,
  output logic [NUM_SOURCES-1:0]               reqGrant,
  output logic                                 protocolError,
  outgoing_port_handler_if.master              link
);

  localparam int PTR_W = $clog2(NUM_SOURCES);

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       win_idx_q;
  logic [NUM_SOURCES-1:0] grant_q;
  logic                   perr_q;
  logic                   vld_q;
  link_word_t             word_q;

  logic [NUM_SOURCES-1:0] eligible;
  logic [PTR_W-1:0]       ptr_adv;
  logic [PTR_W-1:0]       arb_ptr;
  logic [NUM_SOURCES-1:0] arb_grant;
  logic [PTR_W-1:0]       arb_idx;
  logic                   arb_any;
  logic                   capture;
  link_word_t             sel_word;
  logic                   sel_perr;
  logic [1:0]             sel_op;

  // A source granted last cycle is still retiring reqValid; skip it once.
  assign eligible = reqValid & ~grant_q;

  // Pointer after a handshake of the word currently held.
  assign ptr_adv = (win_idx_q == PTR_W'(NUM_SOURCES - 1)) ? '0 : win_idx_q + 1'b1;

  // A back-to-back capture in SEND only happens on a handshake, and then must
  // already see the advanced pointer.
  assign arb_ptr = (state_q == SEND) ? ptr_adv : rr_ptr_q;

  rr_arbiter #(
    .N     (NUM_SOURCES),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i   (eligible),
    .ptr_i   (arb_ptr),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // Winner's fields, selected by the one-hot grant.
  always_comb begin
    sel_word = '0;
    sel_perr = 1'b0;
    sel_op   = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (arb_grant[i]) begin
        sel_op             = resolve_op(reqRead[i], reqWrite[i]);
        sel_word.dest      = reqDestAddr[i*DEST_W +: DEST_W];
        sel_word.requester = reqRequesterAddr[i*ROUTER_ADDR_W +: ROUTER_ADDR_W];
        sel_word.read      = sel_op[1];
        sel_word.write     = sel_op[0];
        sel_word.data      = reqData[i*DATA_W +: DATA_W];
        sel_perr           = reqRead[i] & reqWrite[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          capture = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // Frozen until accepted; no timeout.
        if (link.readyIn) begin
          rr_ptr_d = ptr_adv;
          if (arb_any) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- capture stage: link word, grant and error pulses registered ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      win_idx_q <= '0;
      grant_q   <= '0;
      perr_q    <= 1'b0;
      vld_q     <= 1'b0;
      word_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      vld_q    <= (state_d == SEND);
      grant_q  <= capture ? arb_grant : '0;
      perr_q   <= capture & sel_perr;
      if (capture) begin
        word_q    <= sel_word;
        win_idx_q <= arb_idx;
      end
    end
  end

  assign reqGrant                   = grant_q;
  assign protocolError              = perr_q;
  assign link.validOut              = vld_q;
  assign link.destinationAddressOut = word_q.dest;
  assign link.requesterAddressOut   = word_q.requester;
  assign link.readOut               = word_q.read;
  assign link.writeOut              = word_q.write;
  assign link.dataOut               = word_q.data;

endmodule

// File: tb/tb_outgoing_port_handler.sv
module tb_outgoing_port_handler;
  import outgoing_port_handler_pkg::*;

  localparam int N = 4;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [N-1:0]                reqValid;
  logic [N*DEST_W-1:0]         reqDestAddr;
  logic [N*ROUTER_ADDR_W-1:0]  reqRequesterAddr;
  logic [N-1:0]                reqRead;
  logic [N-1:0]                reqWrite;
  logic [N*DATA_W-1:0]         reqData;
  logic [N-1:0]                reqGrant;
  logic                        protocolError;

  int checks = 0;
  int errors = 0;

  outgoing_port_handler_if link_if();

  outgoing_port_handler #(.NUM_SOURCES(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .reqValid         (reqValid),
    .reqDestAddr      (reqDestAddr),
    .reqRequesterAddr (reqRequesterAddr),
    .reqRead          (reqRead),
    .reqWrite         (reqWrite),
    .reqData          (reqData),
    .reqGrant         (reqGrant),
    .protocolError    (protocolError),
    .link             (link_if)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete, actual running, required finished");
    $fatal(1, "timeout");
  end

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [DEST_W-1:0] d,
                         input logic [ROUTER_ADDR_W-1:0] r, input logic rd,
                         input logic wr, input logic [DATA_W-1:0] dat);
    reqDestAddr[i*DEST_W +: DEST_W]                      = d;
    reqRequesterAddr[i*ROUTER_ADDR_W +: ROUTER_ADDR_W]   = r;
    reqRead[i]                                           = rd;
    reqWrite[i]                                          = wr;
    reqData[i*DATA_W +: DATA_W]                          = dat;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    reqValid       = '0;
    link_if.readyIn = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    reqValid         = 4'b1111;
    reqDestAddr      = '0;
    reqRequesterAddr = '0;
    reqRead          = '0;
    reqWrite         = '0;
    reqData          = '0;
    link_if.readyIn  = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, 14'h100 + 14'(i), 6'(i + 1), 1'b0, 1'b1, 8'h10 + 8'(i));
    tick();
    tick();
    checks++;
    if (link_if.validOut !== 1'b0 || reqGrant !== 4'b0000 || protocolError !== 1'b0) begin
      $display("FAIL reset_ctrl: actual valid=%b grant=%b perr=%b, required 0 0000 0",
               link_if.validOut, reqGrant, protocolError);
      errors++;
    end
    checks++;
    if (link_if.destinationAddressOut !== 14'h0 || link_if.requesterAddressOut !== 6'h0 ||
        link_if.readOut !== 1'b0 || link_if.writeOut !== 1'b0 || link_if.dataOut !== 8'h0) begin
      $display("FAIL reset_link: actual dest=%h req=%h rd=%b wr=%b data=%h, required all 0",
               link_if.destinationAddressOut, link_if.requesterAddressOut,
               link_if.readOut, link_if.writeOut, link_if.dataOut);
      errors++;
    end
    reset = 1'b0;
    tick();
    checks++;
    if (reqGrant !== 4'b0001 || link_if.validOut !== 1'b1 || link_if.dataOut !== 8'h10) begin
      $display("FAIL reset_first_grant: actual grant=%b valid=%b data=%h, required 0001 1 10",
               reqGrant, link_if.validOut, link_if.dataOut);
      errors++;
    end
    reqValid = '0;
  endtask

  task automatic test_single();
    do_reset();
    link_if.readyIn = 1'b1;
    set_src(2, 14'h2A5, 6'h11, 1'b1, 1'b0, 8'h77);
    reqValid = 4'b0100;
    tick();
    checks++;
    if (link_if.validOut !== 1'b1 || link_if.destinationAddressOut !== 14'h2A5 ||
        link_if.readOut !== 1'b1 || link_if.writeOut !== 1'b0 || reqGrant !== 4'b0100 ||
        link_if.requesterAddressOut !== 6'h11 || link_if.dataOut !== 8'h77) begin
      $display("FAIL single_capture: actual valid=%b dest=%h rd=%b wr=%b grant=%b req=%h data=%h, required 1 2a5 1 0 0100 11 77",
               link_if.validOut, link_if.destinationAddressOut, link_if.readOut,
               link_if.writeOut, reqGrant, link_if.requesterAddressOut, link_if.dataOut);
      errors++;
    end
    reqValid = '0;
    tick();
    checks++;
    if (link_if.validOut !== 1'b0 || reqGrant !== 4'b0000) begin
      $display("FAIL single_release: actual valid=%b grant=%b, required 0 0000",
               link_if.validOut, reqGrant);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 14'h040 + 14'(i), 6'h20 + 6'(i), 1'b0, 1'b1, 8'hA0 + 8'(i));
    link_if.readyIn = 1'b1;
    reqValid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (reqGrant !== exp_g[k] || link_if.validOut !== 1'b1) begin
        $display("FAIL b2b_grant_%0d: actual grant=%b valid=%b, required %b 1",
                 k, reqGrant, link_if.validOut, exp_g[k]);
        errors++;
      end
    end
    checks++;
    if (link_if.dataOut !== 8'hA0) begin
      $display("FAIL b2b_data: actual %h, required a0", link_if.dataOut);
      errors++;
    end
    reqValid = '0;
    tick();
    checks++;
    if (link_if.validOut !== 1'b0 || reqGrant !== 4'b0000) begin
      $display("FAIL b2b_drain: actual valid=%b grant=%b, required 0 0000",
               link_if.validOut, reqGrant);
      errors++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_src(1, 14'h1234, 6'h05, 1'b1, 1'b0, 8'h3C);
    set_src(3, 14'h0ABC, 6'h2E, 1'b0, 1'b1, 8'h00);
    link_if.readyIn = 1'b0;
    reqValid = 4'b1010;
    tick();
    checks++;
    if (reqGrant !== 4'b0010 || link_if.dataOut !== 8'h3C) begin
      $display("FAIL bp_capture: actual grant=%b data=%h, required 0010 3c", reqGrant, link_if.dataOut);
      errors++;
    end
    reqValid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      reqData[3*DATA_W +: DATA_W] = 8'h91 + 8'(k);
      tick();
      checks++;
      if (link_if.validOut !== 1'b1 || link_if.destinationAddressOut !== 14'h1234 ||
          link_if.requesterAddressOut !== 6'h05 || link_if.readOut !== 1'b1 ||
          link_if.writeOut !== 1'b0 || link_if.dataOut !== 8'h3C || reqGrant !== 4'b0000) begin
        $display("FAIL bp_hold_%0d: actual valid=%b dest=%h req=%h rd=%b wr=%b data=%h grant=%b, required 1 1234 05 1 0 3c 0000",
                 k, link_if.validOut, link_if.destinationAddressOut, link_if.requesterAddressOut,
                 link_if.readOut, link_if.writeOut, link_if.dataOut, reqGrant);
        errors++;
      end
    end
    link_if.readyIn = 1'b1;
    tick();
    checks++;
    if (reqGrant !== 4'b1000 || link_if.validOut !== 1'b1 ||
        link_if.dataOut !== 8'h95 || link_if.destinationAddressOut !== 14'h0ABC) begin
      $display("FAIL bp_next: actual grant=%b valid=%b data=%h dest=%h, required 1000 1 95 0abc",
               reqGrant, link_if.validOut, link_if.dataOut, link_if.destinationAddressOut);
      errors++;
    end
    reqValid = '0;
    tick();
    checks++;
    if (link_if.validOut !== 1'b0) begin
      $display("FAIL bp_drain: actual valid=%b, required 0", link_if.validOut);
      errors++;
    end
  endtask

  task automatic test_protocol_error();
    do_reset();
    set_src(0, 14'h0333, 6'h3F, 1'b1, 1'b1, 8'h5C);
    link_if.readyIn = 1'b1;
    reqValid = 4'b0001;
    tick();
    checks++;
    if (link_if.writeOut !== 1'b1 || link_if.readOut !== 1'b0 || protocolError !== 1'b1 ||
        link_if.dataOut !== 8'h5C || reqGrant !== 4'b0001) begin
      $display("FAIL perr_capture: actual wr=%b rd=%b perr=%b data=%h grant=%b, required 1 0 1 5c 0001",
               link_if.writeOut, link_if.readOut, protocolError, link_if.dataOut, reqGrant);
      errors++;
    end
    reqValid = '0;
    tick();
    checks++;
    if (protocolError !== 1'b0 || link_if.validOut !== 1'b0) begin
      $display("FAIL perr_pulse: actual perr=%b valid=%b, required 0 0", protocolError, link_if.validOut);
      errors++;
    end
  endtask

  task automatic test_reset_in_send();
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 14'h200 + 14'(i), 6'h08, 1'b0, 1'b1, 8'hC0 + 8'(i));
    link_if.readyIn = 1'b1;
    reqValid = 4'b0010;
    tick();
    // src1 is accepted next edge (pointer moves to 2) while src2 is captured and stalls.
    reqValid = 4'b0100;
    tick();
    link_if.readyIn = 1'b0;
    checks++;
    if (reqGrant !== 4'b0100 || link_if.validOut !== 1'b1) begin
      $display("FAIL rst_send_setup: actual grant=%b valid=%b, required 0100 1", reqGrant, link_if.validOut);
      errors++;
    end
    reset = 1'b1;
    reqValid = 4'b1111;
    tick();
    checks++;
    if (link_if.validOut !== 1'b0 || reqGrant !== 4'b0000 || link_if.dataOut !== 8'h00) begin
      $display("FAIL rst_send_drop: actual valid=%b grant=%b data=%h, required 0 0000 00",
               link_if.validOut, reqGrant, link_if.dataOut);
      errors++;
    end
    reset = 1'b0;
    tick();
    checks++;
    if (reqGrant !== 4'b0001) begin
      $display("FAIL rst_send_ptr: actual grant=%b, required 0001", reqGrant);
      errors++;
    end
    reqValid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_protocol_error();
    test_reset_in_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
